motor_timer_ctrl: RTL and testbench
===================================

# motor_timer_ctrl

Motor-control FSM that sits in front of `timer_counter` and a fan motor driver. It turns three debounced buttons into a speed level and a timer mode. It drives the timer's mode select and clear, and consumes the timer's seconds count and done flag. On timer expiry it stops the motor and reports the remaining seconds for display. It shares `timer_counter`'s 1 kHz tick clock.

## Interface
Parameters:
- `PWM_PERIOD`, 100: PWM period in clocks; duty values are in the range 0..`PWM_PERIOD`.
- `DUTY1`, 25: high-time clocks for speed 1.
- `DUTY2`, 50: high-time clocks for speed 2.
- `DUTY3`, 75: high-time clocks for speed 3.

Ports:
- `i_clk` in 1: system clock, same as `timer_counter`.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_btn_speed` in 1: speed button; synchronous, debounced level.
- `i_btn_timer` in 1: timer-mode button; synchronous, debounced level.
- `i_btn_stop` in 1: stop button; synchronous, debounced level.
- `i_timer_sec` in 6: elapsed seconds from the timer.
- `i_timer_state` in 1: timer done flag.
- `o_timer_sw` out 2: timer mode. 0 = free-run, 1/2/3 = 10/20/30 s.
- `o_timer_clr` out 1: one-cycle pulse that clears the timer; wired OR'd into the timer's reset.
- `o_speed` out 2: current speed level, 0 = off.
- `o_pwm` out 1: motor PWM output.
- `o_remain_sec` out 6: seconds left in the current timed mode.

## Operation
- **Edge detect:** each button has its own previous-sample register. An event is `btn & ~prev`. Holding a button produces exactly one event.
- **States:** `IDLE` (motor off) and `RUN`.
- **In `IDLE`:**
  - Speed event: go to `RUN`, `o_speed`=1, `o_timer_sw`=0, pulse `o_timer_clr`.
  - Timer and stop events are ignored.
- **In `RUN`:**
  - Speed event: `o_speed` cycles 1→2→3→1. The timer is untouched.
  - Timer event: `o_timer_sw` cycles 0→1→2→3→0, and `o_timer_clr` pulses.
  - Stop event: go to `IDLE`, `o_speed`=0, `o_timer_sw`=0, pulse `o_timer_clr`.
  - Timer done, when `o_timer_sw`≠0, `i_timer_state`=1 and the guard is 0: same action as a stop event.
- **Guard:** a 2-bit guard counter is loaded with 2 on every `o_timer_clr` pulse and decrements to 0. The done flag is ignored while the guard is nonzero, which masks a stale done from the previous mode.
- **Simultaneous events, priority order:**
  1. stop
  2. timer-done
  3. speed
  4. timer button

  Only the highest-priority event acts in a given cycle; the others are dropped.
- **Remaining seconds:**
  - limit = 10/20/30 for `o_timer_sw` = 1/2/3.
  - `o_remain_sec` = limit − `i_timer_sec`, saturating at 0.
  - `o_remain_sec` = 0 when `o_timer_sw`=0 or in `IDLE`.
- **PWM counter:** `pwm_cnt` runs free 0..`PWM_PERIOD`−1 and wraps.
  - The active duty register loads the target duty (`DUTYn` for speed n, 0 for speed 0) when `pwm_cnt`=`PWM_PERIOD`−1.
  - `o_pwm` = registered (`pwm_cnt` < active duty) AND state==`RUN`.
  - A transition to `IDLE` forces `o_pwm` low on the next edge, without waiting for the period boundary.
- **Arithmetic:** all compares are unsigned. The `pwm_cnt` width is $clog2(`PWM_PERIOD`). Duty values are in the range 0..`PWM_PERIOD`; `DUTYn`=`PWM_PERIOD` gives a constant high.

## Timing
- **Reset values:** all outputs are 0, state=`IDLE`, `pwm_cnt`=0, active duty=0, guard=0, and the prev registers are 0.
- **Event latency:** `o_speed`, `o_timer_sw`, `o_timer_clr` and the state update at the first rising edge where the button is 1 and its prev is 0.
- **Clear pulse:** `o_timer_clr` is high for exactly one cycle.
- **`o_remain_sec`:** registered, so it lags `i_timer_sec` by 1 clock.
- **Speed change:** takes effect on `o_pwm` at the next PWM period start. The latency is at most `PWM_PERIOD`+1 clocks.
- **Done latency:** from `i_timer_state` rising (guard 0) to `o_speed`=0 is 1 clock; `o_pwm` is 0 on the same edge.
- **Reset mid-PWM-period:** `o_pwm` drops asynchronously, and the counter restarts at 0.

## Configuration
- `MOTOR_SOFT_START_EN` defined:
  - At each period boundary, the active duty steps toward the target by at most `PWM_PERIOD`/20 per period when increasing.
  - Decreases still load directly.
  - `IDLE`→`RUN` therefore ramps up from 0.
- `MOTOR_SOFT_START_EN` undefined: the active duty loads the target directly at each boundary.

## Test plan
- **Reset and start:** reset, release, one speed pulse → `o_speed`=1, `o_timer_clr` high for 1 cycle, `o_pwm` high for 25 of every 100 clocks from the next period.
- **Speed cycling:** four speed pulses in `RUN` → `o_speed` 2, 3, 1, 2; duty after each boundary is 50/75/25/50; `o_timer_clr` never pulses.
- **Timed stop:**
  - Setup: timer button once → `o_timer_sw`=1, clear pulse.
  - Drive `i_timer_sec` 0..10, and `i_timer_state`=1 at 10 → `o_remain_sec` 10..0.
  - One clock after the done flag → `IDLE`, `o_speed`=0, `o_timer_sw`=0, `o_pwm`=0, clear pulse.
- **Stale done and guard:**
  - `i_timer_state` held 1 while the timer button changes mode 1→2 → no stop during the 2 guard cycles.
  - Flag still 1 after the guard expires → stop occurs.
- **Simultaneous events:** stop and speed asserted on the same edge in `RUN` → `IDLE`, `o_speed`=0; a speed event alone in `IDLE` with the timer button also high → `RUN`, `o_timer_sw`=0.
- **Soft start (`MOTOR_SOFT_START_EN`):** `IDLE`→speed 3 → active duty 5, 10, …, 75 over 15 periods; stop → `o_pwm` low on the next clock.

Source files
------------

// File: rtl/motor_timer_ctrl.sv
// rtl/motor_timer_ctrl.sv - fan motor speed/timer control FSM with PWM drive
//
// Turns three debounced buttons into a speed level and a timer mode, drives
// timer_counter's mode select and clear, and stops the motor on timer expiry.
// Optional feature macro: MOTOR_SOFT_START_EN. When it is defined, the active
// duty ramps up by PWM_PERIOD/20 per period.
//
// Ports:
//   i_clk            system clock (shared with timer_counter)
//   i_reset          asynchronous active-high reset
//   i_btn_speed      speed button, debounced level
//   i_btn_timer      timer-mode button, debounced level
//   i_btn_stop       stop button, debounced level
//   i_timer_sec      elapsed seconds from the timer
//   i_timer_state    timer done flag
//   o_timer_sw       timer mode: 0 free-run, 1/2/3 = 10/20/30 s
//   o_timer_clr      one-cycle timer clear pulse
//   o_speed          speed level, 0 = off
//   o_pwm            motor PWM output
//   o_remain_sec     seconds left in the current timed mode
module motor_timer_ctrl #(
    parameter int PWM_PERIOD = 100,
    parameter int DUTY1      = 25,
    parameter int DUTY2      = 50,
    parameter int DUTY3      = 75
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    input  logic       i_btn_stop,
    input  logic [5:0] i_timer_sec,
    input  logic       i_timer_state,
    output logic [1:0] o_timer_sw,
    output logic       o_timer_clr,
    output logic [1:0] o_speed,
    output logic       o_pwm,
    output logic [5:0] o_remain_sec
);

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    // Duty must be able to hold PWM_PERIOD itself (constant-high case).
    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
`ifdef MOTOR_SOFT_START_EN
    localparam int STEP = (PWM_PERIOD / 20 > 0) ? PWM_PERIOD / 20 : 1;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      speed_q, speed_d;
    logic [1:0]      sw_q, sw_d;
    logic            clr_q, clr_d;
    logic [1:0]      guard_q, guard_d;
    logic [5:0]      remain_q, remain_d;
    logic [CW-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic            pwm_q, pwm_d;
    logic            prev_speed_q, prev_timer_q, prev_stop_q;

    logic            ev_speed, ev_timer, ev_stop, done_hit;
    logic [5:0]      limit;
    logic [DW-1:0]   target;
    logic [DW-1:0]   cnt_ext;

    assign ev_speed = i_btn_speed & ~prev_speed_q;
    assign ev_timer = i_btn_timer & ~prev_timer_q;
    assign ev_stop  = i_btn_stop  & ~prev_stop_q;

    // The guard masks a done flag left over from the mode before the last clear.
    assign done_hit = (sw_q != 2'd0) && i_timer_state && (guard_q == 2'd0);

    // FSM next state, speed, mode and clear pulse; priority stop > done > speed > timer.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        sw_d    = sw_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_speed) begin
                    state_d = RUN;
                    speed_d = 2'd1;
                    sw_d    = 2'd0;
                    clr_d   = 1'b1;
                end
            end
            RUN: begin
                if (ev_stop || done_hit) begin
                    state_d = IDLE;
                    speed_d = 2'd0;
                    sw_d    = 2'd0;
                    clr_d   = 1'b1;
                end else if (ev_speed) begin
                    speed_d = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
                end else if (ev_timer) begin
                    sw_d  = sw_q + 2'd1;
                    clr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = 2'd0;
                sw_d    = 2'd0;
            end
        endcase
    end

    always_comb begin
        guard_d = guard_q;
        if (clr_d) begin
            guard_d = 2'd2;
        end else if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
        end
    end

    // Remaining seconds follow the post-edge mode so IDLE always shows 0.
    always_comb begin
        limit = 6'd0;
        case (sw_d)
            2'd1:    limit = 6'd10;
            2'd2:    limit = 6'd20;
            2'd3:    limit = 6'd30;
            default: limit = 6'd0;
        endcase
        remain_d = 6'd0;
        if ((state_d == RUN) && (sw_d != 2'd0) && (i_timer_sec < limit)) begin
            remain_d = limit - i_timer_sec;
        end
    end

    always_comb begin
        target = '0;
        case (speed_q)
            2'd1:    target = DW'(DUTY1);
            2'd2:    target = DW'(DUTY2);
            2'd3:    target = DW'(DUTY3);
            default: target = '0;
        endcase
    end

    assign cnt_ext = DW'(pwm_cnt_q);

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + CW'(1);
        duty_d    = duty_q;
        if (pwm_cnt_q == CNT_LAST) begin
`ifdef MOTOR_SOFT_START_EN
            if (target > duty_q) begin
                if (({1'b0, duty_q} + (DW + 1)'(STEP)) > {1'b0, target}) begin
                    duty_d = target;
                end else begin
                    duty_d = duty_q + DW'(STEP);
                end
            end else begin
                duty_d = target;
            end
`else
            duty_d = target;
`endif
        end
        // Gating with the next state drops the output on the edge that stops the motor.
        pwm_d = (state_d == RUN) && (cnt_ext < duty_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            speed_q      <= 2'd0;
            sw_q         <= 2'd0;
            clr_q        <= 1'b0;
            guard_q      <= 2'd0;
            remain_q     <= 6'd0;
            pwm_cnt_q    <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
            prev_speed_q <= 1'b0;
            prev_timer_q <= 1'b0;
            prev_stop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            sw_q         <= sw_d;
            clr_q        <= clr_d;
            guard_q      <= guard_d;
            remain_q     <= remain_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            prev_speed_q <= i_btn_speed;
            prev_timer_q <= i_btn_timer;
            prev_stop_q  <= i_btn_stop;
        end
    end

    assign o_timer_sw   = sw_q;
    assign o_timer_clr  = clr_q;
    assign o_speed      = speed_q;
    assign o_pwm        = pwm_q;
    assign o_remain_sec = remain_q;

endmodule

// File: tb/tb_motor_timer_ctrl.sv
// tb/tb_motor_timer_ctrl.sv - self-checking bench for motor_timer_ctrl
module tb_motor_timer_ctrl;

    localparam int P  = 100;
    localparam int D1 = 25;
    localparam int D2 = 50;
    localparam int D3 = 75;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_spd, b_tmr, b_stp, t_state;
    logic [5:0] t_sec;
    logic [1:0] sw, spd;
    logic       clr, pwm;
    logic [5:0] remain;

    always #5 clk = ~clk;

    motor_timer_ctrl #(
        .PWM_PERIOD(P), .DUTY1(D1), .DUTY2(D2), .DUTY3(D3)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_btn_speed(b_spd), .i_btn_timer(b_tmr), .i_btn_stop(b_stp),
        .i_timer_sec(t_sec), .i_timer_state(t_state),
        .o_timer_sw(sw), .o_timer_clr(clr), .o_speed(spd),
        .o_pwm(pwm), .o_remain_sec(remain)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: motor on/off, speed, mode, guard cycles left, period
    // position and the duty in force for the current period.
    bit m_run, m_clr, m_pwm;
    int m_speed, m_sw, m_guard, m_duty, m_phase, m_remain;
    bit p_spd, p_tmr, p_stp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int duty_of(input int s);
        case (s)
            1: return D1;
            2: return D2;
            3: return D3;
            default: return 0;
        endcase
    endfunction

    function automatic int limit_of(input int m);
        return m * 10;
    endfunction

    task automatic model_reset();
        m_run = 0; m_clr = 0; m_pwm = 0;
        m_speed = 0; m_sw = 0; m_guard = 0; m_duty = 0; m_phase = 0; m_remain = 0;
        p_spd = 0; p_tmr = 0; p_stp = 0;
    endtask

    task automatic model_edge();
        bit es, et, ep, done;
        int old_speed, old_duty, tgt;
        es = b_spd && !p_spd;
        et = b_tmr && !p_tmr;
        ep = b_stp && !p_stp;
        p_spd = b_spd; p_tmr = b_tmr; p_stp = b_stp;
        old_speed = m_speed;
        old_duty  = m_duty;
        done = m_run && (m_sw != 0) && t_state && (m_guard == 0);
        m_clr = 0;
        if (!m_run) begin
            if (es) begin m_run = 1; m_speed = 1; m_sw = 0; m_clr = 1; end
        end else if (ep || done) begin
            m_run = 0; m_speed = 0; m_sw = 0; m_clr = 1;
        end else if (es) begin
            m_speed = m_speed % 3 + 1;
        end else if (et) begin
            m_sw = (m_sw + 1) % 4; m_clr = 1;
        end
        m_guard = m_clr ? 2 : ((m_guard > 0) ? m_guard - 1 : 0);
        m_remain = 0;
        if (m_run && m_sw != 0 && limit_of(m_sw) > int'(t_sec))
            m_remain = limit_of(m_sw) - int'(t_sec);
        m_pwm = m_run && (m_phase < old_duty);
        if (m_phase == P - 1) begin
            tgt = duty_of(old_speed);
`ifdef MOTOR_SOFT_START_EN
            if (tgt > old_duty) m_duty = (old_duty + P / 20 > tgt) ? tgt : old_duty + P / 20;
            else m_duty = tgt;
`else
            m_duty = tgt;
`endif
        end
        m_phase = (m_phase + 1) % P;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("speed", spd, m_speed);
        check("timer_sw", sw, m_sw);
        check("timer_clr", clr, m_clr);
        check("remain_sec", remain, m_remain);
        check("pwm", pwm, m_pwm);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pwm === 1'b1) highs++;
        end
    endtask

    task automatic pulse_speed();
        b_spd = 1; step(); b_spd = 0; step();
    endtask

    int highs;
    int exp_seq[4] = '{2, 3, 1, 2};
    int exp_duty[4] = '{D2, D3, D1, D2};
    int settle;
    bit got;

    initial begin
`ifdef MOTOR_SOFT_START_EN
        settle = 1700;
`else
        settle = 110;
`endif
        rst = 1; b_spd = 0; b_tmr = 0; b_stp = 0; t_state = 0; t_sec = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_speed", spd, 0);
        check("rst_sw", sw, 0);
        check("rst_clr", clr, 0);
        check("rst_pwm", pwm, 0);
        check("rst_remain", remain, 0);
        @(negedge clk); rst = 0;

        // Start: one speed pulse, clear pulses for one cycle, 25% duty.
        b_spd = 1; step();
        check("start_speed", spd, 1);
        check("start_clr", clr, 1);
        b_spd = 0; step();
        check("start_clr_end", clr, 0);
        run(settle);
        count_high(P, highs);
        check("start_duty", highs, D1);

        // Speed cycling 2,3,1,2 with no clear pulse.
        for (int k = 0; k < 4; k++) begin
            b_spd = 1; step();
            check("cycle_speed", spd, exp_seq[k]);
            check("cycle_noclr", clr, 0);
            b_spd = 0; step();
            run(settle);
            count_high(P, highs);
            check("cycle_duty", highs, exp_duty[k]);
        end

        // Timed stop in 10 s mode.
        b_tmr = 1; step();
        check("timed_sw", sw, 1);
        check("timed_clr", clr, 1);
        b_tmr = 0; run(3);
        for (int s = 0; s <= 10; s++) begin
            t_sec = 6'(s);
            t_state = (s == 10);
            step();
            check("timed_remain", remain, 10 - s);
        end
        check("timed_stop_speed", spd, 0);
        check("timed_stop_sw", sw, 0);
        check("timed_stop_pwm", pwm, 0);
        check("timed_stop_clr", clr, 1);
        t_state = 0; t_sec = 0; step();

        // Stale done masked for two guard cycles after a mode change.
        pulse_speed();
        b_tmr = 1; step(); b_tmr = 0; run(3);
        b_tmr = 1; step();
        check("guard_sw", sw, 2);
        b_tmr = 0; t_state = 1;
        step(); check("guard_hold1", spd, 1);
        step(); check("guard_hold2", spd, 1);
        step(); check("guard_stop", spd, 0);
        check("guard_stop_clr", clr, 1);
        t_state = 0; step();

        // Speed event in IDLE with timer button high; stop+speed together in RUN.
        b_spd = 1; b_tmr = 1; step();
        check("idle_speed", spd, 1);
        check("idle_sw", sw, 0);
        b_spd = 0; b_tmr = 0; run(2);
        b_spd = 1; b_stp = 1; step();
        check("simul_speed", spd, 0);
        check("simul_pwm", pwm, 0);
        b_spd = 0; b_stp = 0; step();

        // Reset in the middle of a high PWM phase.
        pulse_speed();
        got = 0;
        for (int i = 0; i < 3 * P && !got; i++) begin
            step();
            if (pwm === 1'b1) got = 1;
        end
        check("pwm_seen_high", got, 1);
        #2 rst = 1;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_speed", spd, 0);
        model_reset();
        @(negedge clk); rst = 0;

        // Ramp to speed 3 from IDLE, then stop drops PWM on the next clock.
        pulse_speed(); pulse_speed(); pulse_speed();
        run(16 * P);
        count_high(P, highs);
        check("speed3_duty", highs, D3);
        b_stp = 1; step();
        check("stop_pwm", pwm, 0);
        b_stp = 0; step();

        // Randomized phase.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(7) == 0) b_spd = ~b_spd;
            if ($urandom_range(9) == 0) b_tmr = ~b_tmr;
            if ($urandom_range(40) == 0) b_stp = ~b_stp;
            if ($urandom_range(3) == 0) t_sec = 6'($urandom_range(35));
            t_state = ($urandom_range(15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
